// File: rtl/cgra_rotating_register_file.sv
// Multi-port register file for a CGRA processing element. A rotating base pointer
// remaps logical addresses to physical entries, which is what modulo-scheduled loops need.
module cgra_rotating_register_file #(
    parameter int LOG2REGS = 3,
    parameter int SIZE     = 32,
    parameter int NUM_WR   = 2,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                         CGRA_Clock,
    input  logic                         CGRA_Reset,
    input  logic                         clear,
    input  logic                         rotate,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*LOG2REGS-1:0]   waddr,
    input  logic [NUM_WR*SIZE-1:0]       wdata,
    input  logic [NUM_RD*LOG2REGS-1:0]   raddr,
    output logic [NUM_RD*SIZE-1:0]       rdata,
    output logic [LOG2REGS-1:0]          base
);

    localparam int DEPTH = 1 << LOG2REGS;

    logic [SIZE-1:0]        r_mem [DEPTH];
    logic [LOG2REGS-1:0]    r_base;
    logic [NUM_RD*SIZE-1:0] r_rdata;

    logic [LOG2REGS-1:0]    w_wphys    [NUM_WR];
    logic [LOG2REGS-1:0]    w_rphys    [NUM_RD];
    logic [DEPTH-1:0]       w_ent_we;
    logic [SIZE-1:0]        w_ent_data [DEPTH];
    logic [NUM_RD*SIZE-1:0] w_rd_next;

    // Translation uses the base held before the edge; natural overflow gives the mod-D wrap.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            w_wphys[k] = waddr[k*LOG2REGS +: LOG2REGS] + r_base;
        end
        for (int r = 0; r < NUM_RD; r++) begin
            w_rphys[r] = raddr[r*LOG2REGS +: LOG2REGS] + r_base;
        end
    end

    // Per-entry write decode. Ports are scanned in ascending order so the
    // highest-numbered enabled port targeting an entry is the last to assign it.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional
        // assignment; otherwise a missed branch would hold its value and infer a latch.
        w_ent_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_data[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && (w_wphys[k] == LOG2REGS'(i))) begin
                    w_ent_we[i]   = 1'b1;
                    w_ent_data[i] = wdata[k*SIZE +: SIZE];
                end
            end
        end
    end

    // Next read data: array contents, optionally overridden by the winning
    // same-cycle write to the same logical address (same base, so same physical entry).
    always_comb begin
        w_rd_next = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            w_rd_next[r*SIZE +: SIZE] = r_mem[w_rphys[r]];
            if (BYPASS) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (we[k] && (waddr[k*LOG2REGS +: LOG2REGS] == raddr[r*LOG2REGS +: LOG2REGS])) begin
                        w_rd_next[r*SIZE +: SIZE] = wdata[k*SIZE +: SIZE];
                    end
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset) begin
            r_base  <= '0;
            r_rdata <= '0;
            // NOTE: the storage array is reset explicitly because power-on and
            // mid-run reset must both leave every entry at zero; this keeps it in flops.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_base  <= '0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (rotate) begin
                r_base <= r_base + LOG2REGS'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ent_we[i]) begin
                    r_mem[i] <= w_ent_data[i];
                end
            end
            r_rdata <= w_rd_next;
        end
    end

    assign rdata = r_rdata;
    assign base  = r_base;

endmodule

// File: tb/tb_cgra_rotating_register_file.sv
// Directed bench: one bypassing and one non-bypassing instance share the same
// stimulus so both read behaviours are checked side by side.
module tb_cgra_rotating_register_file;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             rotate;
    logic [1:0]       we;
    logic [1:0][2:0]  waddr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0][2:0]  raddr_v;
    logic [1:0][31:0] rdata_b;
    logic [1:0][31:0] rdata_n;
    logic [2:0]       base_b;
    logic [2:0]       base_n;

    int n_cmp = 0;
    int n_err = 0;

    cgra_rotating_register_file #(
        .LOG2REGS(3), .SIZE(32), .NUM_WR(2), .NUM_RD(2), .BYPASS(1'b1)
    ) dut_byp (
        .CGRA_Clock(clk), .CGRA_Reset(rst_n), .clear(clear), .rotate(rotate),
        .we(we), .waddr(waddr_v), .wdata(wdata_v), .raddr(raddr_v),
        .rdata(rdata_b), .base(base_b)
    );

    cgra_rotating_register_file #(
        .LOG2REGS(3), .SIZE(32), .NUM_WR(2), .NUM_RD(2), .BYPASS(1'b0)
    ) dut_nb (
        .CGRA_Clock(clk), .CGRA_Reset(rst_n), .clear(clear), .rotate(rotate),
        .we(we), .waddr(waddr_v), .wdata(wdata_v), .raddr(raddr_v),
        .rdata(rdata_n), .base(base_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear   = 1'b0;
        rotate  = 1'b0;
        we      = 2'b00;
        waddr_v = '0;
        wdata_v = '0;
    endtask

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        raddr_v = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cmp32("reset_rdata0_byp", rdata_b[0], 32'h0);
        cmp32("reset_rdata1_nb", rdata_n[1], 32'h0);
        cmp32("reset_base_byp", {29'd0, base_b}, 32'h0);
        // Write 0xDEADBEEF to logical 3 while rotating, then read it back via logical 2.
        we = 2'b01; waddr_v[0] = 3'd3; wdata_v[0] = 32'hDEADBEEF; rotate = 1'b1;
        tick();
        idle();
        raddr_v[0] = 3'd2;
        tick();
        cmp32("pre_reset_base", {29'd0, base_b}, 32'd1);
        cmp32("pre_reset_read_nb", rdata_n[0], 32'hDEADBEEF);
        // Asynchronous assertion mid-cycle, with a write and rotate pending.
        we = 2'b01; waddr_v[0] = 3'd4; wdata_v[0] = 32'h55555555; rotate = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        cmp32("async_rdata0_byp", rdata_b[0], 32'h0);
        cmp32("async_rdata0_nb", rdata_n[0], 32'h0);
        cmp32("async_base_nb", {29'd0, base_n}, 32'h0);
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        raddr_v[0] = 3'd3;
        raddr_v[1] = 3'd5;
        tick();
        cmp32("post_reset_addr3", rdata_b[0], 32'h0);
        cmp32("post_reset_addr5", rdata_n[1], 32'h0);
        cmp32("post_reset_base", {29'd0, base_b}, 32'h0);
    endtask

    task automatic test_basic();
        idle();
        we = 2'b01; waddr_v[0] = 3'd5; wdata_v[0] = 32'h12345678;
        raddr_v[0] = 3'd5;
        tick();
        cmp32("basic_edge0_nb", rdata_n[0], 32'h0);
        cmp32("basic_edge0_byp", rdata_b[0], 32'h12345678);
        idle();
        tick();
        cmp32("basic_edge1_nb", rdata_n[0], 32'h12345678);
        cmp32("basic_edge1_byp", rdata_b[0], 32'h12345678);
    endtask

    task automatic test_bypass_conflict();
        idle();
        we = 2'b11;
        waddr_v[0] = 3'd2; wdata_v[0] = 32'hAAAA0000;
        waddr_v[1] = 3'd2; wdata_v[1] = 32'h0000BBBB;
        raddr_v[0] = 3'd2; raddr_v[1] = 3'd5;
        tick();
        cmp32("conflict_bypass_byp", rdata_b[0], 32'h0000BBBB);
        cmp32("conflict_bypass_nb", rdata_n[0], 32'h0);
        cmp32("conflict_other_port", rdata_b[1], 32'h12345678);
        idle();
        tick();
        cmp32("conflict_later_byp", rdata_b[0], 32'h0000BBBB);
        cmp32("conflict_later_nb", rdata_n[0], 32'h0000BBBB);
        // Distinct targets in one cycle; read port 1 bypasses from write port 0.
        we = 2'b11;
        waddr_v[0] = 3'd6; wdata_v[0] = 32'h66666666;
        waddr_v[1] = 3'd7; wdata_v[1] = 32'h77777777;
        raddr_v[0] = 3'd7; raddr_v[1] = 3'd6;
        tick();
        cmp32("dual_bypass_p0", rdata_b[0], 32'h77777777);
        cmp32("dual_bypass_p1", rdata_b[1], 32'h66666666);
        idle();
        tick();
        cmp32("dual_later_nb0", rdata_n[0], 32'h77777777);
        cmp32("dual_later_nb1", rdata_n[1], 32'h66666666);
    endtask

    task automatic test_rotation();
        idle();
        we = 2'b11;
        waddr_v[0] = 3'd0; wdata_v[0] = 32'h11;
        waddr_v[1] = 3'd1; wdata_v[1] = 32'h22;
        tick();
        idle();
        rotate = 1'b1;
        tick();
        cmp32("rot_base1", {29'd0, base_b}, 32'd1);
        rotate = 1'b0;
        raddr_v[0] = 3'd0; raddr_v[1] = 3'd7;
        tick();
        cmp32("rot_logical0", rdata_n[0], 32'h22);
        cmp32("rot_logical7_wrap", rdata_b[1], 32'h11);
        rotate = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        cmp32("rot_base7", {29'd0, base_n}, 32'd7);
        tick();
        cmp32("rot_wrap_to0", {29'd0, base_b}, 32'd0);
        tick();
        cmp32("rot_base1_again", {29'd0, base_n}, 32'd1);
        rotate = 1'b0;
        tick();
        cmp32("rot_logical0_again", rdata_b[0], 32'h22);
    endtask

    task automatic test_rotate_write();
        idle();
        clear = 1'b1;
        tick();
        cmp32("rw_clear_base", {29'd0, base_b}, 32'd0);
        idle();
        we = 2'b01; waddr_v[0] = 3'd4; wdata_v[0] = 32'h77; rotate = 1'b1;
        tick();
        cmp32("rw_base", {29'd0, base_b}, 32'd1);
        idle();
        raddr_v[0] = 3'd3; raddr_v[1] = 3'd4;
        tick();
        cmp32("rw_logical3_byp", rdata_b[0], 32'h77);
        cmp32("rw_logical3_nb", rdata_n[0], 32'h77);
        cmp32("rw_logical4_empty", rdata_b[1], 32'h0);
    endtask

    task automatic test_clear_priority();
        idle();
        for (int i = 0; i < 8; i++) begin
            we = 2'b01;
            waddr_v[0] = 3'(i);
            wdata_v[0] = 32'h100 + 32'(i);
            tick();
        end
        idle();
        raddr_v[0] = 3'd6; raddr_v[1] = 3'd1;
        tick();
        cmp32("fill_read6", rdata_n[0], 32'h106);
        cmp32("fill_read1", rdata_n[1], 32'h101);
        clear = 1'b1; rotate = 1'b1;
        we = 2'b01; waddr_v[0] = 3'd0; wdata_v[0] = 32'hFF;
        raddr_v[0] = 3'd0;
        tick();
        cmp32("clr_rdata0_byp", rdata_b[0], 32'h0);
        cmp32("clr_rdata1_nb", rdata_n[1], 32'h0);
        cmp32("clr_base_byp", {29'd0, base_b}, 32'h0);
        cmp32("clr_base_nb", {29'd0, base_n}, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) begin
            raddr_v[0] = 3'(2 * i);
            raddr_v[1] = 3'(2 * i + 1);
            tick();
            cmp32($sformatf("clr_entry%0d", 2 * i), rdata_n[0], 32'h0);
            cmp32($sformatf("clr_entry%0d", 2 * i + 1), rdata_b[1], 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        // Consecutive writes to one address with a read each cycle.
        raddr_v[0] = 3'd5;
        we = 2'b10; waddr_v[1] = 3'd5;
        wdata_v[1] = 32'hA1;
        tick();
        cmp32("b2b_first_byp", rdata_b[0], 32'hA1);
        cmp32("b2b_first_nb", rdata_n[0], 32'h0);
        wdata_v[1] = 32'hA2;
        tick();
        cmp32("b2b_second_byp", rdata_b[0], 32'hA2);
        cmp32("b2b_second_nb", rdata_n[0], 32'hA1);
        idle();
        tick();
        cmp32("b2b_settled_nb", rdata_n[0], 32'hA2);
    endtask

    initial begin
        rst_n = 1'b0;
        raddr_v = '0;
        idle();
        test_reset();
        test_basic();
        test_bypass_conflict();
        test_rotation();
        test_rotate_write();
        test_clear_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
